// File: rtl/wb_pkg.sv
// Shared types for the classic-to-pipelined Wishbone bridge: FSM states,
// response codes and the timeout counter width rule.
package wb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

  typedef enum logic [1:0] {RSP_NONE, RSP_ACK, RSP_ERR} rsp_t;

  // A zero TIMEOUT disables the counter, but it still needs one bit to exist.
  function automatic int tmo_cnt_width(input int tmo);
    return (tmo > 0) ? $clog2(tmo + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_timeout.sv
// Request timeout counter: cleared when a request starts, counts each
// enabled cycle, and flags the cycle that reaches TIMEOUT.
module wb_timeout
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 255
)(
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = tmo_cnt_width(TIMEOUT);

  logic [CW-1:0] r_cnt;

  // Counting stops once expired, so the counter can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_cnt <= '0;
    else if (i_clear)                 r_cnt <= '0;
    else if (i_enable && !o_expired)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = (TIMEOUT != 0) && i_enable && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_std2pipe_bridge.sv
// Classic Wishbone slave to pipelined Wishbone master bridge: one
// outstanding transfer, all outputs registered, with timeout and abort.
module wb_std2pipe_bridge
  import wb_pkg::*;
#(
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 16,
  parameter int SEL_WIDTH = DAT_WIDTH / 8,
  parameter int TIMEOUT   = 255
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_cyc_i,
  input  logic                 s_stb_i,
  input  logic                 s_we_i,
  input  logic [ADR_WIDTH-1:0] s_adr_i,
  input  logic [DAT_WIDTH-1:0] s_dat_i,
  input  logic [SEL_WIDTH-1:0] s_sel_i,
  output logic [DAT_WIDTH-1:0] s_dat_o,
  output logic                 s_ack_o,
  output logic                 s_err_o,
  output logic                 m_cyc_o,
  output logic                 m_stb_o,
  output logic                 m_we_o,
  output logic [ADR_WIDTH-1:0] m_adr_o,
  output logic [DAT_WIDTH-1:0] m_dat_o,
  output logic [SEL_WIDTH-1:0] m_sel_o,
  input  logic [DAT_WIDTH-1:0] m_dat_i,
  input  logic                 m_ack_i,
  input  logic                 m_err_i,
  input  logic                 m_stall_i
);

  state_t               r_state, w_state_nx;
  rsp_t                 w_rsp;
  logic                 r_m_cyc, r_m_stb, r_m_we, r_s_ack, r_s_err;
  logic                 w_m_cyc, w_m_stb, w_m_we, w_s_ack, w_s_err;
  logic [ADR_WIDTH-1:0] r_m_adr, w_m_adr;
  logic [DAT_WIDTH-1:0] r_m_dat, w_m_dat, r_s_dat, w_s_dat;
  logic [SEL_WIDTH-1:0] r_m_sel, w_m_sel;
  logic                 w_tmo_clr, w_tmo_en, w_tmo_exp;

  wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_tmo_clr),
    .i_enable (w_tmo_en),
    .o_expired(w_tmo_exp)
  );

  always_comb begin
    w_state_nx = r_state;
    w_rsp      = RSP_NONE;
    w_m_cyc    = r_m_cyc;
    w_m_stb    = r_m_stb;
    w_m_we     = r_m_we;
    w_m_adr    = r_m_adr;
    w_m_dat    = r_m_dat;
    w_m_sel    = r_m_sel;
    w_s_dat    = r_s_dat;
    w_s_ack    = 1'b0;
    w_s_err    = 1'b0;
    w_tmo_clr  = 1'b0;
    w_tmo_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          w_m_cyc    = 1'b1;
          w_m_stb    = 1'b1;
          w_m_we     = s_we_i;
          w_m_adr    = s_adr_i;
          w_m_dat    = s_dat_i;
          w_m_sel    = s_sel_i;
          w_tmo_clr  = 1'b1;
          w_state_nx = ST_REQ;
        end
      end
      ST_REQ, ST_WAIT: begin
        w_tmo_en = 1'b1;
        if (r_state == ST_REQ && !m_stall_i) begin
          w_m_stb    = 1'b0;
          w_state_nx = ST_WAIT;
        end
        // Ack only counts once the request is accepted; err always wins.
        if (m_err_i)
          w_rsp = RSP_ERR;
        else if (m_ack_i && (r_state == ST_WAIT || !m_stall_i))
          w_rsp = RSP_ACK;
        else if (w_tmo_exp)
          w_rsp = RSP_ERR;
        if (!s_cyc_i) begin
          w_m_cyc    = 1'b0;
          w_m_stb    = 1'b0;
          w_state_nx = ST_IDLE;
        end else if (w_rsp != RSP_NONE) begin
          w_m_cyc    = 1'b0;
          w_m_stb    = 1'b0;
          w_s_ack    = (w_rsp == RSP_ACK);
          w_s_err    = (w_rsp == RSP_ERR);
          if (w_rsp == RSP_ACK && !r_m_we) w_s_dat = m_dat_i;
          w_state_nx = ST_RESP;
        end
      end
      ST_RESP: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_m_cyc <= 1'b0;
      r_m_stb <= 1'b0;
      r_m_we  <= 1'b0;
      r_m_adr <= '0;
      r_m_dat <= '0;
      r_m_sel <= '0;
      r_s_dat <= '0;
      r_s_ack <= 1'b0;
      r_s_err <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_m_cyc <= w_m_cyc;
      r_m_stb <= w_m_stb;
      r_m_we  <= w_m_we;
      r_m_adr <= w_m_adr;
      r_m_dat <= w_m_dat;
      r_m_sel <= w_m_sel;
      r_s_dat <= w_s_dat;
      r_s_ack <= w_s_ack;
      r_s_err <= w_s_err;
    end
  end

  assign m_cyc_o = r_m_cyc;
  assign m_stb_o = r_m_stb;
  assign m_we_o  = r_m_we;
  assign m_adr_o = r_m_adr;
  assign m_dat_o = r_m_dat;
  assign m_sel_o = r_m_sel;
  assign s_dat_o = r_s_dat;
  assign s_ack_o = r_s_ack;
  assign s_err_o = r_s_err;

endmodule

// File: tb/tb_wb_std2pipe_bridge.sv
// Bench for wb_std2pipe_bridge: classic master driver, pipelined slave
// responder and a word-memory reference model with byte-select merging.
module tb_wb_std2pipe_bridge;
  localparam int AW = 16, DW = 16, SW = 2, TMO = 8;

  logic          clk = 1'b0, rst = 1'b1;
  logic          s_cyc_i = 1'b0, s_stb_i = 1'b0, s_we_i = 1'b0;
  logic [AW-1:0] s_adr_i = '0;
  logic [DW-1:0] s_dat_i = '0;
  logic [SW-1:0] s_sel_i = '0;
  logic [DW-1:0] s_dat_o;
  logic          s_ack_o, s_err_o, m_cyc_o, m_stb_o, m_we_o;
  logic [AW-1:0] m_adr_o;
  logic [DW-1:0] m_dat_o;
  logic [SW-1:0] m_sel_o;
  logic [DW-1:0] m_dat_i = '0;
  logic          m_ack_i = 1'b0, m_err_i = 1'b0, m_stall_i = 1'b0;

  wb_std2pipe_bridge #(.ADR_WIDTH(AW), .DAT_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_sel_i(s_sel_i),
    .s_dat_o(s_dat_o), .s_ack_o(s_ack_o), .s_err_o(s_err_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_stall_i(m_stall_i)
  );

  always #5 clk = ~clk;

  int            checks = 0, failures = 0;
  logic [DW-1:0] slv_mem [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_sdat;

  // Reference: a word store where each selected byte lane is replaced.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] sel);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Drives one classic transfer and plays the pipelined slave; records what it saw.
  task automatic run_txn(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
      input logic [SW-1:0] sel, input int stall, input int ackd, input bit do_err,
      input bit no_rsp, input bit keep, output logic [DW-1:0] rdat, output int lat,
      output int nack, output int nerr, output int stbc, output bit fld_ok, output bit cyc_end);
    int since;
    bit done;
    since = -1; done = 0; lat = -1; nack = 0; nerr = 0; stbc = 0;
    fld_ok = 1; cyc_end = 1; rdat = '0;
    s_cyc_i = 1; s_stb_i = 1; s_we_i = we; s_adr_i = adr; s_dat_i = dat; s_sel_i = sel;
    m_stall_i = 0; m_ack_i = 0; m_err_i = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk); #1;
      m_ack_i = 0; m_err_i = 0; m_stall_i = 0;
      if (since >= 0) since++;
      if (s_ack_o || s_err_o) begin
        nack = int'(s_ack_o); nerr = int'(s_err_o); lat = c;
        rdat = s_dat_o; cyc_end = m_cyc_o; done = 1;
      end else begin
        if (m_stb_o) begin
          stbc++;
          if (m_adr_o !== adr || m_dat_o !== dat || m_we_o !== we || m_sel_o !== sel ||
              m_cyc_o !== 1'b1) fld_ok = 0;
          m_stall_i = (stbc <= stall);
          if (!m_stall_i) begin
            since = 0;
            if (we) slv_mem[m_adr_o[7:0]] = merge(slv_mem[m_adr_o[7:0]], m_dat_o, m_sel_o);
          end
        end
        if (!no_rsp && since == ackd) begin
          m_ack_i = 1; m_err_i = do_err; m_dat_i = slv_mem[m_adr_o[7:0]];
        end
      end
    end
    m_ack_i = 0; m_err_i = 0; m_stall_i = 0;
    if (!keep) begin
      s_cyc_i = 0; s_stb_i = 0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({m_cyc_o, m_stb_o, m_we_o, s_ack_o, s_err_o, m_adr_o, m_dat_o, s_dat_o, m_sel_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got cyc=%b stb=%b adr=%h dat=%h sdat=%h want all zero",
               m_cyc_o, m_stb_o, m_adr_o, m_dat_o, s_dat_o);
    end
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;
    checks++;
    if ({m_cyc_o, m_stb_o, s_ack_o, s_err_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_release_idle: cyc=%b stb=%b ack=%b err=%b want 0", m_cyc_o, m_stb_o, s_ack_o, s_err_o);
    end
    exp_sdat = '0;
  endtask

  task automatic test_write_basic();
    logic [DW-1:0] rd; int lat, na, ne, sc; bit fo, ce;
    run_txn(1, 16'd5, 16'd105, 2'b11, 0, 1, 0, 0, 0, rd, lat, na, ne, sc, fo, ce);
    ref_mem[5] = merge(ref_mem[5], 16'd105, 2'b11);
    checks++;
    if (!fo) begin failures++; $display("FAIL write_fields: master fields wrong, want adr=5 dat=105 we=1 sel=3"); end
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL write_latency: got %0d want 3", lat); end
    checks++;
    if (na !== 1 || ne !== 0 || sc !== 1) begin
      failures++; $display("FAIL write_resp: ack=%0d err=%0d stb_cycles=%0d want 1 0 1", na, ne, sc);
    end
    checks++;
    if (rd !== exp_sdat) begin failures++; $display("FAIL write_keeps_sdat: got %h want %h", rd, exp_sdat); end
  endtask

  task automatic test_read_stall();
    logic [DW-1:0] rd; int lat, na, ne, sc; bit fo, ce;
    run_txn(0, 16'd5, 16'd0, 2'b11, 4, 1, 0, 0, 0, rd, lat, na, ne, sc, fo, ce);
    exp_sdat = ref_mem[5];
    checks++;
    if (sc !== 5 || !fo) begin failures++; $display("FAIL stall_stb_cycles: got %0d fields_ok=%0b want 5 1", sc, fo); end
    checks++;
    if (rd !== 16'd105) begin failures++; $display("FAIL stall_read_data: got %0d want 105", rd); end
    checks++;
    if (lat !== 7 || na !== 1 || ne !== 0) begin
      failures++; $display("FAIL stall_resp: lat=%0d ack=%0d err=%0d want 7 1 0", lat, na, ne);
    end
    checks++;
    if (s_ack_o !== 1'b0 || m_cyc_o !== 1'b0) begin
      failures++; $display("FAIL stall_single_pulse: ack=%b cyc=%b one cycle later want 0 0", s_ack_o, m_cyc_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd; int lat, na, ne, sc, total; bit fo, ce;
    total = 0;
    for (int i = 0; i < 20; i++) begin
      bit wr; logic [AW-1:0] a; logic [DW-1:0] d;
      wr = (i < 10); a = AW'(11 + i % 10); d = DW'(211 + i % 10);
      run_txn(wr, a, wr ? d : '0, 2'b11, 0, 1, 0, 0, (i != 19), rd, lat, na, ne, sc, fo, ce);
      total += lat;
      if (wr) ref_mem[a[7:0]] = merge(ref_mem[a[7:0]], d, 2'b11);
      else exp_sdat = ref_mem[a[7:0]];
      checks++;
      if (lat !== ((i == 0) ? 3 : 4) || na !== 1 || !fo) begin
        failures++; $display("FAIL b2b_txn%0d: lat=%0d ack=%0d fields_ok=%0b", i, lat, na, fo);
      end
      if (!wr) begin
        checks++;
        if (rd !== ref_mem[a[7:0]]) begin
          failures++; $display("FAIL b2b_readback adr=%0d: got %0d want %0d", a, rd, ref_mem[a[7:0]]);
        end
      end
    end
    checks++;
    if (total !== 3 + 19 * 4) begin failures++; $display("FAIL b2b_total_cycles: got %0d want %0d", total, 3 + 19 * 4); end
  endtask

  task automatic test_random();
    logic [DW-1:0] rd; int lat, na, ne, sc; bit fo, ce;
    int errs;
    errs = 0;
    for (int n = 0; n < 40; n++) begin
      bit wr; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] sl; int st, ad;
      wr = 1'($urandom_range(0, 1)); a = AW'($urandom_range(0, 15)); d = DW'($urandom);
      sl = SW'($urandom_range(1, 3)); st = $urandom_range(0, 3); ad = $urandom_range(0, 3);
      run_txn(wr, a, d, sl, st, ad, 0, 0, 0, rd, lat, na, ne, sc, fo, ce);
      if (wr) ref_mem[a[7:0]] = merge(ref_mem[a[7:0]], d, sl);
      else exp_sdat = ref_mem[a[7:0]];
      checks++;
      if (lat !== 2 + st + ad || na !== 1 || ne !== 0 || sc !== st + 1 || !fo || ce !== 1'b0 ||
          rd !== exp_sdat) begin
        failures++; errs++;
        if (errs < 5)
          $display("FAIL random_txn%0d we=%0b adr=%0d: lat=%0d/%0d ack=%0d stb=%0d/%0d rd=%h/%h",
                   n, wr, a, lat, 2 + st + ad, na, sc, st + 1, rd, exp_sdat);
      end
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] rd; int lat, na, ne, sc; bit fo, ce;
    run_txn(0, 16'd3, 16'd0, 2'b11, 0, 0, 0, 1, 0, rd, lat, na, ne, sc, fo, ce);
    checks++;
    if (lat !== TMO + 1 || ne !== 1 || na !== 0) begin
      failures++; $display("FAIL timeout_err: lat=%0d err=%0d ack=%0d want %0d 1 0", lat, ne, na, TMO + 1);
    end
    checks++;
    if (ce !== 1'b0 || rd !== exp_sdat) begin failures++; $display("FAIL timeout_cyc_sdat: cyc=%b sdat=%h want 0 %h", ce, rd, exp_sdat); end
    run_txn(0, 16'd5, 16'd0, 2'b11, 1, 2, 0, 0, 0, rd, lat, na, ne, sc, fo, ce);
    exp_sdat = ref_mem[5];
    checks++;
    if (na !== 1 || lat !== 5 || rd !== ref_mem[5]) begin
      failures++; $display("FAIL timeout_recover: ack=%0d lat=%0d rd=%h want 1 5 %h", na, lat, rd, ref_mem[5]);
    end
  endtask

  task automatic test_err_ack();
    logic [DW-1:0] rd; int lat, na, ne, sc; bit fo, ce;
    run_txn(0, 16'd12, 16'd0, 2'b11, 0, 1, 1, 0, 0, rd, lat, na, ne, sc, fo, ce);
    checks++;
    if (ne !== 1 || na !== 0 || lat !== 3) begin
      failures++; $display("FAIL err_wins: err=%0d ack=%0d lat=%0d want 1 0 3", ne, na, lat);
    end
    checks++;
    if (rd !== exp_sdat) begin failures++; $display("FAIL err_keeps_sdat: got %h want %h", rd, exp_sdat); end
  endtask

  task automatic test_abort();
    int resp;
    s_cyc_i = 1; s_stb_i = 1; s_we_i = 0; s_adr_i = 16'd9; s_sel_i = 2'b11; m_stall_i = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (m_cyc_o !== 1'b1 || m_stb_o !== 1'b0) begin
      failures++; $display("FAIL abort_in_wait: cyc=%b stb=%b want 1 0", m_cyc_o, m_stb_o);
    end
    s_cyc_i = 0; s_stb_i = 0;
    @(posedge clk); #1;
    checks++;
    if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0) begin
      failures++; $display("FAIL abort_drop: cyc=%b stb=%b want 0 0", m_cyc_o, m_stb_o);
    end
    m_ack_i = 1; m_dat_i = 16'hdead; resp = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      m_ack_i = 0;
      resp += int'(s_ack_o | s_err_o);
    end
    checks++;
    if (resp !== 0 || s_dat_o !== exp_sdat) begin
      failures++; $display("FAIL abort_late_ack: responses=%0d sdat=%h want 0 %h", resp, s_dat_o, exp_sdat);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd; int lat, na, ne, sc, resp; bit fo, ce;
    s_cyc_i = 1; s_stb_i = 1; s_we_i = 1; s_adr_i = 16'h00a7; s_dat_i = 16'hbeef; s_sel_i = 2'b11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    #1;
    checks++;
    if ({m_cyc_o, m_stb_o, m_we_o, s_ack_o, s_err_o, m_adr_o, m_dat_o, s_dat_o, m_sel_o} !== '0) begin
      failures++;
      $display("FAIL reset_async: cyc=%b stb=%b we=%b adr=%h dat=%h sdat=%h sel=%b want all zero",
               m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, s_dat_o, m_sel_o);
    end
    s_cyc_i = 0; s_stb_i = 0;
    @(posedge clk); #1; rst = 0;
    exp_sdat = '0;
    m_ack_i = 1; resp = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      m_ack_i = 0;
      resp += int'(s_ack_o | s_err_o | m_cyc_o);
    end
    checks++;
    if (resp !== 0) begin failures++; $display("FAIL reset_no_resp: activity=%0d want 0", resp); end
    slv_mem[1] = 16'h1234; ref_mem[1] = 16'h1234;
    run_txn(0, 16'd1, 16'd0, 2'b11, 0, 1, 0, 0, 0, rd, lat, na, ne, sc, fo, ce);
    checks++;
    if (rd !== ref_mem[1] || na !== 1 || lat !== 3) begin
      failures++; $display("FAIL reset_post_read: rd=%h ack=%0d lat=%0d want %h 1 3", rd, na, lat, ref_mem[1]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin slv_mem[i] = '0; ref_mem[i] = '0; end
    exp_sdat = '0;
    test_reset();
    test_write_basic();
    test_read_stall();
    test_back_to_back();
    test_random();
    test_timeout();
    test_err_ack();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_std2pipe_bridge.md
WB_STD2PIPE_BRIDGE -- requirements
Module: wb_std2pipe_bridge

Interface
REQ-001 Parameters: ADR_WIDTH, default 16, address bits; DAT_WIDTH, default 16, data bits (multiple of 8); SEL_WIDTH, default DAT_WIDTH/8, byte selects; TIMEOUT, default 255, max clocks from request to response.
REQ-002 clk  input  1  single clock, all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 s_cyc_i, s_stb_i, s_we_i  input  1 each  classic (standard) slave-port cycle, strobe, write enable.
REQ-005 s_adr_i  input  ADR_WIDTH; s_dat_i  input  DAT_WIDTH; s_sel_i  input  SEL_WIDTH  slave-port request fields.
REQ-006 s_dat_o  output  DAT_WIDTH; s_ack_o, s_err_o  output  1 each  slave-port response.
REQ-007 m_cyc_o, m_stb_o, m_we_o  output  1 each; m_adr_o  output  ADR_WIDTH; m_dat_o  output  DAT_WIDTH; m_sel_o  output  SEL_WIDTH  pipelined master-port request.
REQ-008 m_dat_i  input  DAT_WIDTH; m_ack_i, m_err_i, m_stall_i  input  1 each  pipelined master-port response and flow control.

Function
REQ-009 FSM states: IDLE, REQ, WAIT, RESP; all outputs registered.
REQ-010 IDLE: s_cyc_i&s_stb_i sampled high -> latch adr/dat/we/sel into master-port registers, m_cyc_o=1, m_stb_o=1, go REQ.
REQ-011 REQ: m_stb_o held with fields stable while m_stall_i=1; at edge with m_stall_i=0 request accepted, m_stb_o=0 next cycle, go WAIT.
REQ-012 WAIT: m_ack_i=1 -> capture m_dat_i into s_dat_o (reads only; writes leave s_dat_o unchanged), m_cyc_o=0, s_ack_o=1, go RESP.
REQ-013 m_ack_i or m_err_i asserted in REQ on the accepting edge is treated as in WAIT (zero-wait slave supported).
REQ-014 m_err_i=1 in REQ/WAIT -> m_cyc_o=0, s_err_o=1, go RESP; m_err_i with m_ack_i simultaneous: err wins, ack suppressed.
REQ-015 RESP: s_ack_o or s_err_o high exactly one cycle, then IDLE; s_stb_i ignored during RESP.
REQ-016 Latency, no stall, ack one cycle after accept: s_stb_i sampled at edge N -> m_stb_o high N+1..N+2 (one cycle) -> s_ack_o high cycle after m_ack_i edge, i.e. 3 cycles after N.
REQ-017 Back-to-back: s_stb_i high in the IDLE cycle following RESP starts new transaction with no extra idle clock.
REQ-018 Timeout counter cleared on IDLE->REQ, increments each cycle in REQ/WAIT; reaching TIMEOUT -> m_cyc_o=0, m_stb_o=0, s_err_o=1, go RESP.
REQ-019 Counter width $clog2(TIMEOUT+1); no wrap possible; TIMEOUT=0 disables timeout.
REQ-020 Abort: s_cyc_i=0 in REQ/WAIT -> m_cyc_o=0, m_stb_o=0 next cycle, go IDLE, no s_ack_o/s_err_o; m_ack_i/m_err_i arriving in IDLE/RESP ignored.
REQ-021 m_cyc_o high continuously from first m_stb_o through response cycle; never high in IDLE.

Reset
REQ-022 rst=1 forces IDLE immediately; m_cyc_o, m_stb_o, m_we_o, s_ack_o, s_err_o = 0; m_adr_o, m_dat_o, s_dat_o = 0; m_sel_o = 0; counter = 0.
REQ-023 rst asserted mid-transaction abandons it; no response generated after release.

Structure
REQ-024 State enum and response-code type live in shared package wb_pkg.
REQ-025 Timeout counter implemented as sub-module wb_timeout (inputs clear, enable; output expired).
REQ-026 Single clock domain; no latches; no combinational path slave input -> master output.

Verification
REQ-027 Write adr=5 dat=105 sel=all-ones, no stall, ack 1 cycle after accept -> m_adr_o=5, m_dat_o=105, m_we_o=1, s_ack_o 3 cycles after stb.
REQ-028 Read adr=5, slave returns 105 with m_stall_i high 4 cycles -> m_stb_o high 5 cycles, s_dat_o=105, single s_ack_o pulse.
REQ-029 10 back-to-back writes adr 11..20 dat 211..220 then reads -> all readbacks match, no idle clock between transactions.
REQ-030 TIMEOUT=8, slave never acks -> s_err_o pulse after 8 cycles in REQ/WAIT, m_cyc_o low, next transaction succeeds.
REQ-031 m_err_i with m_ack_i same cycle -> s_err_o=1, s_ack_o=0; s_cyc_i dropped in WAIT -> no response, later m_ack_i ignored.
REQ-032 rst pulsed during WAIT -> all outputs 0 asynchronously; post-release read adr=1 returns slave data correctly.
